// File: rtl/axis_tx_pkg.sv
// Shared types and helpers for the AXI-Stream frame transmitter.
//   DATA_W / KEEP_W : beat width in bits and byte enables
//   state_t         : transmitter FSM states
//   keep_last()     : byte enables of a frame's final beat from len mod 8
//   beat_data()     : 64-bit little-endian beat of the seed+index pattern,
//                     with lanes outside keep forced to zero
package axis_tx_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // A residue of 0 means the last beat is full; otherwise r low lanes are
  // enabled. Shifting by (8 - r) mod 8 covers both cases in one expression.
  function automatic logic [KEEP_W-1:0] keep_last(input logic [2:0] len_rem);
    keep_last = 8'hFF >> (3'd0 - len_rem);
  endfunction

  // Byte 8*beat_idx + k of the frame equals seed + 8*beat_idx + k (mod 256);
  // the 8-bit shift wraps exactly as the byte arithmetic does.
  function automatic logic [DATA_W-1:0] beat_data(input logic [7:0]        seed,
                                                  input logic [7:0]        beat_idx,
                                                  input logic [KEEP_W-1:0] keep);
    logic [7:0] base;
    beat_data = '0;
    base      = seed + (beat_idx << 3);
    for (int k = 0; k < KEEP_W; k++) begin
      beat_data[8*k +: 8] = keep[k] ? (base + 8'(k)) : 8'h00;
    end
  endfunction

endpackage

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter: each accepted (len, seed, err) request becomes
// one 64-bit AXIS frame of ceil(len/8) beats whose byte i is (seed + i) mod 256.
// Ports:
//   eth_clk, eth_rst            clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_len, req_seed, req_err
//   m_axis_t{valid,ready,data,keep,last,user}  AXIS master beat interface
//   busy                        high while sending or in the inter-frame gap
//   len_err                     one-cycle pulse when a request length is rejected
//   frames_sent, bytes_sent     completed-frame statistics, wrapping mod 2^32
module axis_frame_tx
  import axis_tx_pkg::*;
#(
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1518,
  parameter int IFG_CYCLES = 2
) (
  input  logic              eth_clk,
  input  logic              eth_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_len,
  input  logic [7:0]        req_seed,
  input  logic              req_err,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              busy,
  output logic              len_err,
  output logic [31:0]       frames_sent,
  output logic [31:0]       bytes_sent
);

  localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
  localparam logic [7:0]  GAP_LAST = 8'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  state_t      state, state_nx;
  logic        run;        // low during reset and its release cycle; gates req_ready
  logic [15:0] len_q;
  logic [7:0]  seed_q;
  logic        err_q;
  logic [7:0]  beat_idx;
  logic [7:0]  last_idx;
  logic [7:0]  gap_cnt;
  logic        len_ok;
  logic        accept;
  logic        last_beat;
  logic        beat_hs;

  assign len_ok    = (req_len >= MIN_L) && (req_len <= MAX_L);
  assign accept    = req_valid && run && (state == IDLE);
  assign last_beat = (beat_idx == last_idx);
  assign beat_hs   = (state == SEND) && m_axis_tready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = run;
        if (accept && len_ok) state_nx = SEND;
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = last_beat ? keep_last(len_q[2:0]) : 8'hFF;
        m_axis_tdata  = beat_data(seed_q, beat_idx, m_axis_tkeep);
        m_axis_tlast  = last_beat;
        m_axis_tuser  = last_beat && err_q;
        if (m_axis_tready && last_beat) state_nx = (IFG_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control and statistics registers
  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state       <= IDLE;
      run         <= 1'b0;
      len_err     <= 1'b0;
      gap_cnt     <= '0;
      beat_idx    <= '0;
      frames_sent <= '0;
      bytes_sent  <= '0;
    end else begin
      state   <= state_nx;
      run     <= 1'b1;
      len_err <= accept && !len_ok;
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (accept && len_ok) beat_idx <= '0;
      else if (beat_hs)     beat_idx <= beat_idx + 8'd1;
      if (beat_hs && last_beat) begin
        frames_sent <= frames_sent + 32'd1;
        bytes_sent  <= bytes_sent + {16'd0, len_q};
      end
    end
  end

  // Request fields captured at acceptance
  always_ff @(posedge eth_clk) begin
    if (accept && len_ok) begin
      len_q    <= req_len;
      seed_q   <= req_seed;
      err_q    <= req_err;
      last_idx <= 8'(((req_len + 16'd7) >> 3) - 16'd1);
    end
  end

endmodule
